// File: rtl/pipeline_halt_dump_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_halt_dump_controller
// Purpose  : End-of-program sequencer for the pipelined Data_Path. Watches
//            the fetch PC. When END_PC is fetched it freezes the pipeline and
//            lets in-flight instructions retire for DRAIN_CYCLES cycles. It
//            then reads DUMP_WORDS data-memory words starting at DUMP_BASE and
//            streams them out over a valid/ready interface.
// Ports    : Clk          - rising-edge system clock
//            Reset        - asynchronous active-low reset
//            PCF          - fetch-stage PC (only examined while running)
//            Halt         - freeze request to Data_Path (sticky until reset)
//            Dump_En      - data-memory read-port enable (one-cycle pulse)
//            Dump_Addr    - data-memory word index for the read
//            Dump_RData   - synchronous read data, valid the cycle after Dump_En
//            Out_Valid    - Out_Data/Out_Index hold a dumped word
//            Out_Ready    - sink accepts the word on a rising edge
//            Out_Data     - dumped word
//            Out_Index    - word offset of Out_Data within the dump window
//            Done         - every word has been accepted
//            Cycle_Count  - cycles spent running, saturating
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_halt_dump_controller #(
   parameter logic [31:0] END_PC       = 32'h8c,
   parameter int unsigned DUMP_BASE    = 32,
   parameter int unsigned DUMP_WORDS   = 96,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCF,
   output logic        Halt,
   output logic        Dump_En,
   output logic [31:0] Dump_Addr,
   input  logic [31:0] Dump_RData,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [31:0] Out_Data,
   output logic [15:0] Out_Index,
   output logic        Done,
   output logic [31:0] Cycle_Count
);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_DRAIN = 3'd1,
      S_RD    = 3'd2,
      S_CAP   = 3'd3,
      S_OUT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [7:0]  c_drain_last = 8'(DRAIN_CYCLES - 1);
   localparam logic [15:0] c_idx_last   = 16'(DUMP_WORDS - 1);
   localparam logic [31:0] c_base       = 32'(DUMP_BASE);

   state_t      state_q,       state_d;
   logic [7:0]  drain_cnt_q,   drain_cnt_d;
   logic [15:0] idx_q,         idx_d;
   logic        halt_q,        halt_d;
   logic        dump_en_q,     dump_en_d;
   logic [31:0] dump_addr_q,   dump_addr_d;
   logic        out_valid_q,   out_valid_d;
   logic [31:0] out_data_q,    out_data_d;
   logic [15:0] out_index_q,   out_index_d;
   logic        done_q,        done_d;
   logic [31:0] cycle_count_q, cycle_count_d;

   logic [15:0] idx_next;

   assign idx_next = idx_q + 16'd1;

   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      idx_d         = idx_q;
      halt_d        = halt_q;
      dump_en_d     = 1'b0;          // read enable is a single-cycle pulse
      dump_addr_d   = dump_addr_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_index_d   = out_index_q;
      done_d        = done_q;
      cycle_count_d = cycle_count_q;

      case (state_q)
         S_RUN: begin
            // The matching cycle itself is still counted.
            if (cycle_count_q != 32'hFFFF_FFFF) begin
               cycle_count_d = cycle_count_q + 32'd1;
            end
            if (PCF == END_PC) begin
               state_d     = S_DRAIN;
               halt_d      = 1'b1;
               drain_cnt_d = 8'd0;
            end
         end

         S_DRAIN: begin
            if (drain_cnt_q == c_drain_last) begin
               state_d     = S_RD;
               idx_d       = 16'd0;
               dump_en_d   = 1'b1;
               dump_addr_d = c_base;
            end else begin
               drain_cnt_d = drain_cnt_q + 8'd1;
            end
         end

         S_RD: begin
            state_d = S_CAP;
         end

         S_CAP: begin
            // Memory read data is valid during this cycle only.
            out_data_d  = Dump_RData;
            out_index_d = idx_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end

         S_OUT: begin
            if (Out_Ready) begin
               out_valid_d = 1'b0;
               if (idx_q == c_idx_last) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d       = idx_next;
                  state_d     = S_RD;
                  dump_en_d   = 1'b1;
                  dump_addr_d = c_base + {16'h0000, idx_next};
               end
            end
         end

         S_DONE: begin
            // Terminal until reset; PCF is ignored.
         end

         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= S_RUN;
         drain_cnt_q   <= 8'd0;
         idx_q         <= 16'd0;
         halt_q        <= 1'b0;
         dump_en_q     <= 1'b0;
         dump_addr_q   <= 32'd0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 32'd0;
         out_index_q   <= 16'd0;
         done_q        <= 1'b0;
         cycle_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         idx_q         <= idx_d;
         halt_q        <= halt_d;
         dump_en_q     <= dump_en_d;
         dump_addr_q   <= dump_addr_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_index_q   <= out_index_d;
         done_q        <= done_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign Halt        = halt_q;
   assign Dump_En     = dump_en_q;
   assign Dump_Addr   = dump_addr_q;
   assign Out_Valid   = out_valid_q;
   assign Out_Data    = out_data_q;
   assign Out_Index   = out_index_q;
   assign Done        = done_q;
   assign Cycle_Count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_halt_dump_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_halt_dump_controller
// Purpose  : Self-checking bench. One instance with default parameters is
//            driven through scripted and randomized runs and compared, edge
//            by edge, against a schedule computed from the block's timing
//            rules. A second instance (one word, one drain cycle) is driven
//            from a table of per-edge vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_halt_dump_controller;

   localparam logic [31:0] END_PC = 32'h8c;
   localparam int          BASE   = 32;
   localparam int          W      = 96;
   localparam int          D      = 4;
   localparam int          RDY_N  = 2048;

   logic        Clk;
   int          n_cmp = 0;
   int          n_err = 0;

   // main instance signals
   logic        m_reset, m_halt, m_en, m_valid, m_ready, m_done;
   logic [31:0] m_pcf, m_addr, m_rdata, m_data, m_cnt;
   logic [15:0] m_idx;

   // boundary instance signals
   logic        b_reset, b_halt, b_en, b_valid, b_ready, b_done;
   logic [31:0] b_pcf, b_addr, b_rdata, b_data, b_cnt;
   logic [15:0] b_idx;

   bit          rdy      [0:RDY_N-1];
   int          sched_r  [0:W-1];
   int          sched_a  [0:W-1];

   typedef struct {
      logic [31:0] pcf;
      logic        rdy;
      logic        halt;
      logic        en;
      logic [31:0] addr;
      logic        valid;
      logic [15:0] idx;
      logic [31:0] data;
      logic        done;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs [0:8];

   pipeline_halt_dump_controller u_main (
      .Clk         (Clk),
      .Reset       (m_reset),
      .PCF         (m_pcf),
      .Halt        (m_halt),
      .Dump_En     (m_en),
      .Dump_Addr   (m_addr),
      .Dump_RData  (m_rdata),
      .Out_Valid   (m_valid),
      .Out_Ready   (m_ready),
      .Out_Data    (m_data),
      .Out_Index   (m_idx),
      .Done        (m_done),
      .Cycle_Count (m_cnt)
   );

   pipeline_halt_dump_controller #(
      .DUMP_WORDS   (1),
      .DRAIN_CYCLES (1)
   ) u_bnd (
      .Clk         (Clk),
      .Reset       (b_reset),
      .PCF         (b_pcf),
      .Halt        (b_halt),
      .Dump_En     (b_en),
      .Dump_Addr   (b_addr),
      .Dump_RData  (b_rdata),
      .Out_Valid   (b_valid),
      .Out_Ready   (b_ready),
      .Out_Data    (b_data),
      .Out_Index   (b_idx),
      .Done        (b_done),
      .Cycle_Count (b_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Preloaded memory contents as a fixed function of the word index.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous-read data memories
   always @(posedge Clk) if (m_en) m_rdata <= memf(m_addr);
   always @(posedge Clk) if (b_en) b_rdata <= memf(b_addr);

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_main_reset(input string tag);
      chk1 ({tag, " halt"},  m_halt,  1'b0);
      chk1 ({tag, " en"},    m_en,    1'b0);
      chk32({tag, " addr"},  m_addr,  32'd0);
      chk1 ({tag, " valid"}, m_valid, 1'b0);
      chk32({tag, " data"},  m_data,  32'd0);
      chk32({tag, " idx"},   32'(m_idx), 32'd0);
      chk1 ({tag, " done"},  m_done,  1'b0);
      chk32({tag, " cnt"},   m_cnt,   32'd0);
   endtask

   // mode 0: always ready, 1: random (mostly ready)
   task automatic fill_rdy(input int mode);
      for (int i = 0; i < RDY_N; i++) begin
         rdy[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   endtask

   function automatic logic [31:0] pcf_for(input int e, input int m, input bit ramp);
      logic [31:0] v;
      if (m > 0 && e == m) begin
         v = END_PC;
      end else if (m > 0 && e > m) begin
         v = ($urandom_range(0, 3) == 0) ? END_PC : $urandom;
      end else if (ramp) begin
         v = 32'(4 * (e - 1));
      end else begin
         v = $urandom;
         if (v == END_PC) v = v ^ 32'h1;
      end
      return v;
   endfunction

   // m = edge (counted from reset release) on which END_PC is fetched, 0 = never.
   // Expectations come from a per-word schedule: word k is read on edge r_k,
   // presented from edge r_k+2, accepted on the first ready edge a_k >= r_k+3,
   // and the next read happens on that same edge.
   task automatic run_scenario(input string tag, input int m, input int n_edges,
                               input int stop_idx, input bit ramp);
      int          last_a;
      int          end_e;
      int          r;
      int          ea;
      int          e_k;
      bit          e_en, e_valid, e_done, e_halt;
      logic [31:0] e_cnt;
      string       nm;

      last_a = 0;
      if (m > 0) begin
         r = m + D;
         for (int k = 0; k < W; k++) begin
            ea = r + 3;
            while (ea < RDY_N - 8 && !rdy[ea]) ea++;
            sched_r[k] = r;
            sched_a[k] = ea;
            r = ea;
         end
         last_a = sched_a[W-1];
         end_e  = last_a + 5;
      end else begin
         end_e = n_edges;
      end
      if (end_e > RDY_N - 2) end_e = RDY_N - 2;

      m_reset = 1'b0;
      @(negedge Clk);
      chk_main_reset({tag, " reset"});
      m_pcf   = pcf_for(1, m, ramp);
      m_ready = rdy[1];
      @(negedge Clk);
      m_reset = 1'b1;

      for (int e = 1; e <= end_e; e++) begin
         @(posedge Clk);
         @(negedge Clk);
         e_halt  = (m > 0 && e >= m);
         e_cnt   = e_halt ? 32'(m) : 32'(e);
         e_done  = (m > 0 && e >= last_a);
         e_en    = 1'b0;
         e_valid = 1'b0;
         e_k     = 0;
         if (m > 0) begin
            for (int k = 0; k < W; k++) begin
               if (sched_r[k] == e) begin
                  e_en = 1'b1;
                  e_k  = k;
               end
               if (e >= sched_r[k] + 2 && e < sched_a[k]) begin
                  e_valid = 1'b1;
                  e_k     = k;
               end
            end
         end
         nm = $sformatf("%s e%0d", tag, e);
         chk1 ({nm, " halt"},  m_halt,  e_halt);
         chk1 ({nm, " en"},    m_en,    e_en);
         chk1 ({nm, " valid"}, m_valid, e_valid);
         chk1 ({nm, " done"},  m_done,  e_done);
         chk32({nm, " cnt"},   m_cnt,   e_cnt);
         if (e_en) chk32({nm, " addr"}, m_addr, 32'(BASE + e_k));
         if (e_valid) begin
            chk32({nm, " idx"},  32'(m_idx), 32'(e_k));
            chk32({nm, " data"}, m_data, memf(32'(BASE + e_k)));
         end
         if (stop_idx >= 0 && e_valid && e_k == stop_idx) return;
         m_pcf   = pcf_for(e + 1, m, ramp);
         m_ready = rdy[e + 1];
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset = 1'b0;
      m_pcf   = 32'd0;
      m_ready = 1'b0;
      b_reset = 1'b0;
      b_pcf   = 32'd0;
      b_ready = 1'b0;

      // ---------------- boundary instance: one word, one drain cycle
      //                      pcf     rdy   halt  en    addr   valid idx    data         done  cnt
      vecs[0] = '{32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd0, 32'd0,      1'b0, 32'd1};
      vecs[1] = '{END_PC, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 16'd0, 32'd0,      1'b0, 32'd2};
      vecs[2] = '{32'd0,  1'b1, 1'b1, 1'b1, 32'd32, 1'b0, 16'd0, 32'd0,      1'b0, 32'd2};
      vecs[3] = '{END_PC, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 16'd0, 32'd0,      1'b0, 32'd2};
      vecs[4] = '{32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 16'd0, memf(32'd32), 1'b0, 32'd2};
      vecs[5] = '{END_PC, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 16'd0, memf(32'd32), 1'b0, 32'd2};
      vecs[6] = '{32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 16'd0, 32'd0,      1'b1, 32'd2};
      vecs[7] = '{END_PC, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 16'd0, 32'd0,      1'b1, 32'd2};
      vecs[8] = '{32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 16'd0, 32'd0,      1'b1, 32'd2};

      @(negedge Clk);
      chk1 ("bnd reset halt",  b_halt,  1'b0);
      chk1 ("bnd reset en",    b_en,    1'b0);
      chk1 ("bnd reset valid", b_valid, 1'b0);
      chk1 ("bnd reset done",  b_done,  1'b0);
      chk32("bnd reset cnt",   b_cnt,   32'd0);
      b_pcf   = vecs[0].pcf;
      b_ready = vecs[0].rdy;
      @(negedge Clk);
      b_reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         string nm;
         @(posedge Clk);
         @(negedge Clk);
         nm = $sformatf("bnd v%0d", i);
         chk1 ({nm, " halt"},  b_halt,  vecs[i].halt);
         chk1 ({nm, " en"},    b_en,    vecs[i].en);
         chk1 ({nm, " valid"}, b_valid, vecs[i].valid);
         chk1 ({nm, " done"},  b_done,  vecs[i].done);
         chk32({nm, " cnt"},   b_cnt,   vecs[i].cnt);
         if (vecs[i].en) chk32({nm, " addr"}, b_addr, vecs[i].addr);
         if (vecs[i].valid) begin
            chk32({nm, " idx"},  32'(b_idx), 32'(vecs[i].idx));
            chk32({nm, " data"}, b_data, vecs[i].data);
         end
         if (i < 8) begin
            b_pcf   = vecs[i+1].pcf;
            b_ready = vecs[i+1].rdy;
         end
      end

      // ---------------- default run: PCF ramps 0,4,8,... ready tied high
      fill_rdy(0);
      run_scenario("default", 36, 0, -1, 1'b1);

      // ---------------- backpressure: 7 not-ready edges while word 5 is shown
      fill_rdy(0);
      for (int e = 36 + D + 3 * 5 + 3; e < 36 + D + 3 * 5 + 3 + 7; e++) rdy[e] = 1'b0;
      run_scenario("bp", 36, 0, -1, 1'b1);

      // ---------------- asynchronous reset while word 40 is presented
      fill_rdy(0);
      run_scenario("midrst", 20, 0, 40, 1'b0);
      #2;
      m_reset = 1'b0;
      #1;
      chk_main_reset("async reset");
      run_scenario("after_rst", 10, 0, -1, 1'b0);

      // ---------------- PC never matches
      run_scenario("nomatch", 0, 1000, -1, 1'b0);
      chk32("nomatch final cnt", m_cnt, 32'd1000);

      // ---------------- randomized runs; first one matches on the first edge
      for (int s = 0; s < 3; s++) begin
         int m;
         fill_rdy(1);
         m = (s == 0) ? 1 : int'($urandom_range(2, 60));
         run_scenario($sformatf("rand%0d", s), m, 0, -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_halt_dump_controller.md
# pipeline_halt_dump_controller

Sequences end-of-program handling for the pipelined `Data_Path`. It watches the fetch PC, freezes the pipeline when `END_PC` is reached, and waits a fixed number of cycles so in-flight instructions retire. It then reads a window of data memory through a dedicated read port and streams the words out over a valid/ready interface. It sits beside `Data_Path` in the top level and replaces ad-hoc end-of-run memory dumping with synthesizable sequencing.

## Interface
Parameters:
- `END_PC`, 32'h8c, fetch address that terminates the program.
- `DUMP_BASE`, 32, first data-memory word index to dump.
- `DUMP_WORDS`, 96, number of words to dump (1..65535).
- `DRAIN_CYCLES`, 4, cycles held in DRAIN after halt (1..255).

Ports:
- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `PCF`  in  32  fetch-stage PC from `Data_Path`.
- `Halt`  out  1  freeze request to `Data_Path`: PC/IF-ID hold, bubbles injected downstream.
- `Dump_En`  out  1  data-memory read-port enable.
- `Dump_Addr`  out  32  data-memory word index; valid when `Dump_En`=1.
- `Dump_RData`  in  32  read data, valid the cycle after `Dump_En` (synchronous read).
- `Out_Valid`  out  1  `Out_Data`/`Out_Index` hold a dumped word.
- `Out_Ready`  in  1  sink accepts the word on a rising edge when `Out_Valid`=1.
- `Out_Data`  out  32  dumped word.
- `Out_Index`  out  16  word offset 0..`DUMP_WORDS`-1 of `Out_Data`.
- `Done`  out  1  all words accepted.
- `Cycle_Count`  out  32  RUN cycles elapsed, saturating at 32'hFFFF_FFFF.

## Operation
- States: RUN, DRAIN, RD, CAP, OUT, DONE. All outputs are registered.
- RUN: `Cycle_Count` increments each cycle. When `PCF`==`END_PC` is sampled on an edge, go to DRAIN, set `Halt`=1 and clear the drain counter. `Cycle_Count` stops on that edge; the matching cycle is counted.
- DRAIN: `Halt`=1. The drain counter increments each cycle. After `DRAIN_CYCLES` cycles in DRAIN, go to RD with idx=0.
- RD: `Dump_En`=1, `Dump_Addr`=`DUMP_BASE`+idx. Next state is CAP.
- CAP: `Dump_En`=0. `Dump_RData` is valid in this cycle. On the edge, `Out_Data`<=`Dump_RData`, `Out_Index`<=idx, `Out_Valid`<=1, and the state goes to OUT.
- OUT: `Out_Valid`, `Out_Data` and `Out_Index` hold steady until `Out_Ready`=1 at an edge. On that edge `Out_Valid`<=0. If idx==`DUMP_WORDS`-1, go to DONE; otherwise idx++ and go to RD.
- DONE: `Done`=1 and `Halt`=1 are held until `Reset`. `PCF` is ignored.
- `PCF` is compared only in RUN. X or unrelated values in other states have no effect.
- `Halt` never deasserts after DRAIN is entered, except through reset.
- idx is 16-bit. `Dump_Addr` is `DUMP_BASE` zero-extended plus idx, 32-bit with no overflow check.

## Timing
- Reset values: `Halt`=0, `Dump_En`=0, `Dump_Addr`=0, `Out_Valid`=0, `Out_Data`=0, `Out_Index`=0, `Done`=0, `Cycle_Count`=0, state RUN.
- A `Reset` assertion at any point, including mid-dump with `Out_Valid`=1, clears everything asynchronously. No partial handshake is completed.
- Halt latency: a match sampled on edge E gives `Halt`=1 after E, so the datapath holds from the next edge.
- First `Dump_En` pulse: `DRAIN_CYCLES` cycles after `Halt` rises.
- Per word: RD 1 cycle, CAP 1 cycle, OUT ≥1 cycle. With `Out_Ready` tied high, a new word appears every 3 cycles.
- `Done` rises on the edge that accepts the last word. `Out_Valid` falls on the same edge.
- `Out_Ready` is ignored when `Out_Valid`=0.
- A `PCF` match on the first edge after reset release is honoured normally.

## Test plan
- **Default run.** Stimulus: after reset, drive `PCF` 0,4,8,… one step per cycle, with `Out_Ready`=1. Required response:
  - `Halt` rises the cycle after `PCF`=32'h8c and `Cycle_Count` freezes at 36.
  - `Dump_En` first pulses 4 cycles later with `Dump_Addr`=32.
  - 96 words with `Out_Index` 0..95 come out at 3-cycle spacing, with `Out_Data` equal to the preloaded memory words, then `Done`=1.
- **Backpressure.** Stimulus: drop `Out_Ready` to 0 for 7 cycles while `Out_Index`=5 is presented. Required response: `Out_Valid`, `Out_Data` and `Out_Index` stay stable; `Dump_En` stays 0; word 6 is read only after acceptance.
- **Boundary.** Stimulus: `DUMP_WORDS`=1, `DRAIN_CYCLES`=1. Required response: exactly one `Dump_En` pulse, at word index 32; `Done` rises on the first accept; `Out_Index`=0.
- **Late PCF.** Stimulus: `PCF` pulses to 32'h8c while the block is in DRAIN and again in DONE. Required response: no state change; `Done` and `Halt` stay 1.
- **Reset mid-dump.** Stimulus: assert `Reset`=0 while in OUT with `Out_Index`=40, asynchronously between edges. Required response: all outputs return to their reset values immediately. After release, a fresh match dumps again from `Out_Index` 0.
- **Never-matching PC.** Stimulus: `PCF` never equals `END_PC` for 1000 cycles. Required response: `Halt`=0, `Dump_En`=0, and `Cycle_Count`=1000 after the 1000th edge.
